// File: rtl/reader_cmdgen.sv
// Reader-side Gen2 command serializer: builds QueryRep/Ack/Query/QueryAdj/Nack/ReqRN
// frames, appends CRC5/CRC16 and shifts bits MSB-first per bit_en. Option: CMDGEN_CRC_INJECT_EN.
module reader_cmdgen #(
    parameter int          MAX_BITS     = 40,
    parameter logic [4:0]  CRC5_PRESET  = 5'b01001,
    parameter logic [15:0] CRC16_PRESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en,
    input  logic        start,
    input  logic [2:0]  cmd_sel,
    input  logic        dr,
    input  logic        trext,
    input  logic [1:0]  m,
    input  logic [1:0]  sel,
    input  logic [1:0]  session,
    input  logic        target,
    input  logic [3:0]  q,
    input  logic [2:0]  updn,
    input  logic [15:0] rn16,
`ifdef CMDGEN_CRC_INJECT_EN
    input  logic        crc_corrupt,
`endif
    output logic        bitout,
    output logic        bitout_valid,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, SEND, CRC, FINISH} state_t;
    typedef enum logic [1:0] {CRC_NONE, CRC_5, CRC_16} crc_kind_t;

    state_t              state, state_nx;
    logic [MAX_BITS-1:0] shreg;
    logic [15:0]         crc;
    logic [5:0]          bit_cnt, cnt_nx;
    logic [5:0]          plen_q, flen_q;
    crc_kind_t           kind_q;
    logic                corrupt_q;

    // Load-time decode of the requested command
    logic [23:0]         ld_pay;
    logic [5:0]          ld_plen, ld_flen;
    crc_kind_t           ld_kind;
    logic                ld_legal;
    logic [MAX_BITS-1:0] ld_frame;

    always_comb begin
        ld_pay   = '0;
        ld_plen  = '0;
        ld_flen  = '0;
        ld_kind  = CRC_NONE;
        ld_legal = 1'b1;
        case (cmd_sel)
            3'd0: begin
                ld_pay  = 24'({2'b00, session});
                ld_plen = 6'd4;
                ld_flen = 6'd4;
            end
            3'd1: begin
                ld_pay  = 24'({2'b01, rn16});
                ld_plen = 6'd18;
                ld_flen = 6'd18;
            end
            3'd2: begin
                ld_pay  = 24'({4'b1000, dr, m, trext, sel, session, target, q});
                ld_plen = 6'd17;
                ld_flen = 6'd22;
                ld_kind = CRC_5;
            end
            3'd3: begin
                ld_pay  = 24'({4'b1001, session, updn});
                ld_plen = 6'd9;
                ld_flen = 6'd9;
            end
            3'd5: begin
                ld_pay  = 24'(8'b1100_0000);
                ld_plen = 6'd8;
                ld_flen = 6'd8;
            end
            3'd6: begin
                ld_pay  = {8'b1100_0001, rn16};
                ld_plen = 6'd24;
                ld_flen = 6'd40;
                ld_kind = CRC_16;
            end
            default: ld_legal = 1'b0;
        endcase
        // Left-align the payload so the first bit sits at the MSB
        ld_frame = MAX_BITS'(ld_pay) << (6'(MAX_BITS) - ld_plen);
    end

    // Serial CRC step driven by the outgoing payload bit
    logic        pay_bit, fb5, fb16, crc_bit, last_bit;
    logic [4:0]  crc5_nx;
    logic [15:0] crc16_nx, crc_step;

    always_comb begin
        pay_bit  = shreg[MAX_BITS-1];
        fb5      = pay_bit ^ crc[4];
        fb16     = pay_bit ^ crc[15];
        crc5_nx  = {crc[3:0], 1'b0} ^ (fb5 ? 5'b01001 : 5'b00000);
        crc16_nx = {crc[14:0], 1'b0} ^ (fb16 ? 16'h1021 : 16'h0000);
        crc_step = (kind_q == CRC_16) ? crc16_nx : {11'b0, crc5_nx};
        cnt_nx   = bit_cnt + 6'd1;
        last_bit = (cnt_nx == flen_q);
        // CRC16 goes out ones-complemented; CRC5 goes out as-is
        crc_bit  = (kind_q == CRC_16) ? ~crc[15] : crc[4];
        if (last_bit && corrupt_q)
            crc_bit = ~crc_bit;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && ld_legal) state_nx = SEND;
            SEND:    if (bit_en && cnt_nx == plen_q)
                         state_nx = (kind_q == CRC_NONE) ? FINISH : CRC;
            CRC:     if (bit_en && last_bit) state_nx = FINISH;
            FINISH:  if (bit_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg        <= '0;
            crc          <= '0;
            bit_cnt      <= '0;
            plen_q       <= '0;
            flen_q       <= '0;
            kind_q       <= CRC_NONE;
            bitout       <= 1'b0;
            bitout_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    // bit_en is deliberately ignored here, including on the accept clock
                    if (start && ld_legal) begin
                        shreg   <= ld_frame;
                        plen_q  <= ld_plen;
                        flen_q  <= ld_flen;
                        kind_q  <= ld_kind;
                        crc     <= (ld_kind == CRC_16) ? CRC16_PRESET : {11'b0, CRC5_PRESET};
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end else if (start) begin
                        error <= 1'b1;
                    end
                end
                SEND: if (bit_en) begin
                    bitout       <= pay_bit;
                    bitout_valid <= 1'b1;
                    shreg        <= shreg << 1;
                    crc          <= crc_step;
                    bit_cnt      <= cnt_nx;
                end
                CRC: if (bit_en) begin
                    bitout       <= crc_bit;
                    bitout_valid <= 1'b1;
                    crc          <= crc << 1;
                    bit_cnt      <= cnt_nx;
                end
                FINISH: if (bit_en) begin
                    bitout       <= 1'b0;
                    bitout_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CMDGEN_CRC_INJECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                corrupt_q <= 1'b0;
        else if (state == IDLE && start && ld_legal) corrupt_q <= crc_corrupt;
    end
`else
    assign corrupt_q = 1'b0;
`endif

endmodule

// File: tb/tb_reader_cmdgen.sv
// Directed bench for reader_cmdgen: table of frames plus illegal-command, mid-frame start,
// async reset and (with CMDGEN_CRC_INJECT_EN) CRC corruption sequences.
module tb_reader_cmdgen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_en = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cmd_sel = '0;
    logic        dr = 1'b0, trext = 1'b0, target = 1'b0;
    logic [1:0]  m = '0, sel = '0, session = '0;
    logic [3:0]  q = '0;
    logic [2:0]  updn = '0;
    logic [15:0] rn16 = '0;
`ifdef CMDGEN_CRC_INJECT_EN
    logic        crc_corrupt = 1'b0;
`endif
    logic        bitout, bitout_valid, busy, done, error;

    int tests = 0;
    int fails = 0;

    reader_cmdgen dut (
        .clk          (clk),
        .reset        (reset),
        .bit_en       (bit_en),
        .start        (start),
        .cmd_sel      (cmd_sel),
        .dr           (dr),
        .trext        (trext),
        .m            (m),
        .sel          (sel),
        .session      (session),
        .target       (target),
        .q            (q),
        .updn         (updn),
        .rn16         (rn16),
`ifdef CMDGEN_CRC_INJECT_EN
        .crc_corrupt  (crc_corrupt),
`endif
        .bitout       (bitout),
        .bitout_valid (bitout_valid),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  cmd;
        logic        dr, trext, target;
        logic [1:0]  m, sel, session;
        logic [3:0]  q;
        logic [2:0]  updn;
        logic [15:0] rn16;
        logic [23:0] pay;   // expected payload, right-aligned, first bit is MSB
        int          plen;
        int          flen;
        int          crc;   // 0 none, 5 CRC5, 16 CRC16
        bit          coinc; // bit_en asserted together with start
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver-side residue checks as the tag parser would run them
    function automatic logic [4:0] res5(input logic [63:0] rx, input int n);
        logic [4:0] c = 5'b01001;
        for (int i = 0; i < n; i++) begin
            logic fb = rx[i] ^ c[4];
            c = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
        end
        return c;
    endfunction

    function automatic logic [15:0] res16(input logic [63:0] rx, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            logic fb = rx[i] ^ c[15];
            c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic set_fields(input vec_t v);
        cmd_sel = v.cmd; dr = v.dr; trext = v.trext; target = v.target;
        m = v.m; sel = v.sel; session = v.session; q = v.q; updn = v.updn; rn16 = v.rn16;
    endtask

    task automatic pulse_bit();
        repeat (2) @(negedge clk);
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    // Start a frame and collect bits until done (bounded)
    task automatic run_frame(input bit coinc, output int nbits, output int done_at,
                             output logic [63:0] rx);
        nbits = 0; done_at = -1; rx = '0;
        @(negedge clk);
        start = 1'b1; bit_en = coinc;
        @(negedge clk);
        start = 1'b0; bit_en = 1'b0;
        chk("accept_busy", {63'b0, busy}, 64'd1);
        chk("accept_no_valid", {63'b0, bitout_valid}, 64'd0);
        for (int n = 1; n <= 60 && done_at < 0; n++) begin
            pulse_bit();
            if (done) done_at = n;
            else if (bitout_valid) begin
                rx[nbits] = bitout;
                nbits++;
            end
        end
    endtask

    function automatic logic [23:0] pay_of(input logic [63:0] rx, input int plen);
        logic [23:0] p = '0;
        for (int k = 0; k < plen; k++) p = {p[22:0], rx[k]};
        return p;
    endfunction

    vec_t vecs[7];

    initial begin
        int          nb, da;
        logic [63:0] rx;

        vecs[0] = '{3'd0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 4'h0, 3'b000, 16'h0000,
                    24'({2'b00, 2'b10}), 4, 4, 0, 0};
        vecs[1] = '{3'd1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 16'hA5C3,
                    24'({2'b01, 16'b1010010111000011}), 18, 18, 0, 0};
        vecs[2] = '{3'd2, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'h4, 3'b000, 16'h0000,
                    24'({4'b1000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 4'b0100}), 17, 22, 5, 1};
        vecs[3] = '{3'd3, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'h0, 3'b110, 16'h0000,
                    24'({4'b1001, 2'b01, 3'b110}), 9, 9, 0, 0};
        vecs[4] = '{3'd5, 1, 1, 1, 2'b11, 2'b11, 2'b11, 4'hF, 3'b111, 16'hFFFF,
                    24'(8'b11000000), 8, 8, 0, 1};
        vecs[5] = '{3'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 16'h1234,
                    {8'b11000001, 16'b0001001000110100}, 24, 40, 16, 0};
        vecs[6] = '{3'd2, 0, 1, 1, 2'b01, 2'b11, 2'b10, 4'hF, 3'b000, 16'h0000,
                    24'({4'b1000, 1'b0, 2'b01, 1'b1, 2'b11, 2'b10, 1'b1, 4'b1111}), 17, 22, 5, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {59'b0, bitout, bitout_valid, busy, done, error}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {59'b0, bitout, bitout_valid, busy, done, error}, 64'd0);

        foreach (vecs[i]) begin
            set_fields(vecs[i]);
            run_frame(vecs[i].coinc, nb, da, rx);
            chk($sformatf("v%0d_len", i), 64'(nb), 64'(vecs[i].flen));
            chk($sformatf("v%0d_payload", i), 64'(pay_of(rx, vecs[i].plen)), 64'(vecs[i].pay));
            chk($sformatf("v%0d_done_at", i), 64'(da), 64'(vecs[i].flen + 1));
            if (vecs[i].crc == 5)
                chk($sformatf("v%0d_crc5_res", i), 64'(res5(rx, nb)), 64'd0);
            if (vecs[i].crc == 16)
                chk($sformatf("v%0d_crc16_res", i), 64'(res16(rx, nb)), 64'h1D0F);
            chk($sformatf("v%0d_end_state", i), {62'b0, busy, bitout_valid}, 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_1clk", i), {63'b0, done}, 64'd0);
        end

        // Illegal command selects
        for (int c = 4; c <= 7; c += 3) begin
            cmd_sel = 3'(c);
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk($sformatf("illegal%0d_err", c), {61'b0, error, busy, bitout_valid}, 64'b100);
            @(negedge clk);
            chk($sformatf("illegal%0d_err_1clk", c), {61'b0, error, busy, bitout_valid}, 64'b000);
        end

        // Start while busy is ignored; then async reset at bit 10 aborts
        set_fields(vecs[2]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        rx = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                cmd_sel = 3'd1; m = 2'b01; sel = 2'b11; session = 2'b11; rn16 = 16'hFFFF;
                @(negedge clk); start = 1'b1;
                @(negedge clk); start = 1'b0;
                chk("busy_start_no_err", {62'b0, error, busy}, 64'b01);
            end
            pulse_bit();
            rx[k] = bitout;
        end
        chk("midframe_bits", 64'(pay_of(rx, 10)), 64'(vecs[2].pay >> 7));
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", {59'b0, bitout, bitout_valid, busy, done, error}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulse_bit();
        pulse_bit();
        chk("abort_no_done", {62'b0, done, busy}, 64'd0);

        // Fresh QueryRep after abort
        cmd_sel = 3'd0; session = 2'b11;
        run_frame(1'b0, nb, da, rx);
        chk("qrep_after_reset_len", 64'(nb), 64'd4);
        chk("qrep_after_reset_bits", 64'(pay_of(rx, 4)), 64'b0011);
        chk("qrep_after_reset_done", 64'(da), 64'd5);

`ifdef CMDGEN_CRC_INJECT_EN
        begin
            logic [63:0] clean;
            set_fields(vecs[2]);
            crc_corrupt = 1'b0;
            run_frame(1'b0, nb, da, clean);
            crc_corrupt = 1'b1;
            run_frame(1'b0, nb, da, rx);
            crc_corrupt = 1'b0;
            chk("inject_len", 64'(nb), 64'd22);
            chk("inject_last_inverted", {63'b0, rx[21]}, {63'b0, ~clean[21]});
            chk("inject_rest_same", 64'(rx[20:0]), 64'(clean[20:0]));
            chk("inject_res_nonzero", {63'b0, res5(rx, 22) != 5'd0}, 64'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
